// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low pattern bus (a..g in [7:1], DP in [0]),
// digit glyphs and the slot-state encoding used by the scan driver.
package seg_pkg;

    localparam int SEG_W = 8;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    localparam logic [SEG_W-1:0] SEG_0 = 8'h03;
    localparam logic [SEG_W-1:0] SEG_1 = 8'h9F;
    localparam logic [SEG_W-1:0] SEG_2 = 8'h25;
    localparam logic [SEG_W-1:0] SEG_3 = 8'h0D;
    localparam logic [SEG_W-1:0] SEG_4 = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5 = 8'h49;
    localparam logic [SEG_W-1:0] SEG_6 = 8'h41;
    localparam logic [SEG_W-1:0] SEG_7 = 8'h1F;
    localparam logic [SEG_W-1:0] SEG_8 = 8'h01;
    localparam logic [SEG_W-1:0] SEG_9 = 8'h09;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_e;

    // Counter width with a floor, so narrow configurations still have usable low bits.
    function automatic int width_min(input int n, input int lo);
        int w;
        w = $clog2(n);
        return (w < lo) ? lo : w;
    endfunction

    function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timing for the scan driver: divider, digit index, BLANK/DRIVE state and the
// end-of-frame wrap strobe.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int CW          = width_min(REFRESH_DIV, 3),
    parameter int IW          = width_min(NUM_DIGITS, 1)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] div_cnt_o,
    output logic [IW-1:0] idx_o,
    output slot_state_e   state_o,
    output logic          wrap_o
);

    localparam int BC_M1 = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    slot_state_e   state_q;
    logic          tc, wrap;

    always_comb begin
        tc        = (div_cnt_q == CW'(REFRESH_DIV - 1));
        wrap      = tc && (idx_q == IW'(NUM_DIGITS - 1));
        div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tc) idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= BLANK;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            case (state_q)
                // Enter DRIVE on the edge where the divider reaches BLANK_CYC.
                BLANK: if (BLANK_CYC == 0 || div_cnt_q == CW'(BC_M1)) state_q <= DRIVE;
                DRIVE: if (tc && BLANK_CYC != 0) state_q <= BLANK;
                default: state_q <= BLANK;
            endcase
        end
    end

    assign div_cnt_o = div_cnt_q;
    assign idx_o     = idx_q;
    assign state_o   = state_q;
    assign wrap_o    = wrap;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver with a double-buffered frame input.
// Optional SEG_DIM_EN adds a 3-bit PWM brightness input (dim_level).
module sevenseg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEG_W*NUM_DIGITS-1:0] in_data,
    output logic [SEG_W-1:0]            seg_n,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        frame_start
`ifdef SEG_DIM_EN
    ,
    input  logic [2:0]                  dim_level
`endif
);

    localparam int CW = width_min(REFRESH_DIV, 3);
    localparam int IW = width_min(NUM_DIGITS, 1);

    logic [CW-1:0] div_cnt;
    logic [IW-1:0] idx;
    slot_state_e   state;
    logic          wrap;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .CW         (CW),
        .IW         (IW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .div_cnt_o(div_cnt),
        .idx_o    (idx),
        .state_o  (state),
        .wrap_o   (wrap)
    );

    logic [NUM_DIGITS-1:0][SEG_W-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] pend_q, pend_d;
    logic                             pend_vld_q, pend_vld_d;
    logic                             rdy_q;
    logic [SEG_W-1:0]                 seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]            an_n_q, an_n_d;
    logic                             fs_q, fs_d;
    logic                             accept, drive, lit, dim_ok;

    assign accept = in_valid && rdy_q;
    assign drive  = (state == DRIVE);

`ifdef SEG_DIM_EN
    logic [2:0] phase;
    // Only the low 3 bits of (div_cnt - BLANK_CYC) matter for the mod-8 duty window.
    assign phase  = div_cnt[2:0] - 3'(BLANK_CYC);
    assign dim_ok = (phase <= dim_level);
`else
    assign dim_ok = 1'b1;
`endif

    assign lit = drive && dim_ok;

    always_comb begin
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        // At wrap a pending frame wins; with nothing pending, a same-edge accept bypasses the buffer.
        if (wrap) begin
            if (pend_vld_q) begin
                disp_d     = pend_q;
                pend_vld_d = 1'b0;
            end else if (accept) begin
                disp_d = in_data;
            end
        end else if (accept) begin
            pend_d     = in_data;
            pend_vld_d = 1'b1;
        end

        seg_n_d = drive ? disp_q[idx] : SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n_d[i] = !(lit && (idx == IW'(i)));
        end
        fs_d = (div_cnt == '0) && (idx == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q     <= {NUM_DIGITS{SEG_BLANK}};
            pend_q     <= {NUM_DIGITS{SEG_BLANK}};
            pend_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
            seg_n_q    <= SEG_BLANK;
            an_n_q     <= '1;
            fs_q       <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            rdy_q      <= !pend_vld_d;
            seg_n_q    <= seg_n_d;
            an_n_q     <= an_n_d;
            fs_q       <= fs_d;
        end
    end

    assign in_ready    = rdy_q;
    assign seg_n       = seg_n_q;
    assign an_n        = an_n_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver (NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYC=2).
// Define SEG_DIM_EN for both bench and RTL to cover the dimming port.
module tb_sevenseg_scan_driver;

    localparam int N  = 2;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = N * RD;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [8*N-1:0] in_data = '0;
    logic [7:0]     seg_n;
    logic [N-1:0]   an_n;
    logic           frame_start;
    logic [2:0]     dim_level = 3'd7;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_start(frame_start)
`ifdef SEG_DIM_EN
        ,
        .dim_level  (dim_level)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: position in the frame is plain arithmetic on cycles since reset.
    int unsigned    m_k;
    logic [7:0]     m_disp [N];
    logic [8*N-1:0] m_pend;
    bit             m_pvld;
    bit             m_acc;
    logic [7:0]     e_seg;
    logic [N-1:0]   e_an;
    logic           e_fs;
    logic           e_rdy = 1'b1;

    task automatic tick();
        int pos, dig, dim;
        bit wrap, lit;
        @(posedge clk);
        m_acc = 1'b0;
        if (rst) begin
            m_k = 0;
            for (int i = 0; i < N; i++) m_disp[i] = 8'hFF;
            m_pvld = 1'b0;
            e_seg  = 8'hFF;
            e_an   = '1;
            e_fs   = 1'b0;
            e_rdy  = 1'b1;
        end else begin
            pos = int'(m_k % RD);
            dig = int'((m_k / RD) % N);
            dim = 7;
`ifdef SEG_DIM_EN
            dim = int'(dim_level);
`endif
            lit   = (pos >= BC) && (((pos - BC) % 8) <= dim);
            e_seg = (pos >= BC) ? m_disp[dig] : 8'hFF;
            e_an  = '1;
            if (lit) e_an[dig] = 1'b0;
            e_fs  = (pos == 0) && (dig == 0);
            m_acc = in_valid && e_rdy;
            wrap  = (pos == RD - 1) && (dig == N - 1);
            if (wrap && m_pvld) begin
                for (int i = 0; i < N; i++) m_disp[i] = m_pend[8*i +: 8];
                m_pvld = 1'b0;
            end else if (wrap && m_acc) begin
                for (int i = 0; i < N; i++) m_disp[i] = in_data[8*i +: 8];
            end else if (m_acc) begin
                m_pend = in_data;
                m_pvld = 1'b1;
            end
            e_rdy = !m_pvld;
            m_k++;
        end
        @(negedge clk);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < 2 * FR && (m_k % FR) != phase; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = 16'($urandom);
            tick();
            n_chk++;
            if ({seg_n, an_n, frame_start, in_ready} !== {8'hFF, 2'b11, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL reset c=%0d got seg=%h an=%b fs=%b rdy=%b want FF/11/0/1", c, seg_n, an_n, frame_start, in_ready);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 2 * FR; c++) begin
            tick();
            n_chk++;
            if ({seg_n, an_n, frame_start, in_ready} !== {e_seg, e_an, e_fs, e_rdy} || seg_n !== 8'hFF) begin
                n_err++;
                $display("FAIL post_reset k=%0d got %h/%b/%b/%b want %h/%b/%b/%b", m_k, seg_n, an_n, frame_start, in_ready, e_seg, e_an, e_fs, e_rdy);
            end
        end
    endtask

    task automatic test_load();
        int seen_fs, pulses;
        logic [7:0] xs;
        logic [1:0] xa;
        idle_until(5);
        in_valid = 1'b1;
        in_data  = 16'h9F03;
        tick();
        in_valid = 1'b0;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_ready_drop got %b want 0", in_ready);
        end
        seen_fs = 0;
        for (int i = 0; i < 2 * FR && !seen_fs; i++) begin
            tick();
            seen_fs = int'(e_fs);
        end
        n_chk++;
        if (!seen_fs) begin
            n_err++;
            $display("FAIL load_frame_wait got no frame start want one within %0d cycles", 2 * FR);
        end
        pulses = 0;
        for (int c = 0; c < 2 * FR; c++) begin
            if (c > 0) tick();
            if (c % RD < BC) begin
                xs = 8'hFF; xa = 2'b11;
            end else if ((c / RD) % N == 0) begin
                xs = 8'h03; xa = 2'b10;
            end else begin
                xs = 8'h9F; xa = 2'b01;
            end
            pulses += int'(frame_start === 1'b1);
            n_chk++;
            if ({seg_n, an_n, frame_start} !== {xs, xa, 1'(c % FR == 0)}) begin
                n_err++;
                $display("FAIL load c=%0d got %h/%b/%b want %h/%b/%b", c, seg_n, an_n, frame_start, xs, xa, (c % FR == 0));
            end
        end
        n_chk++;
        if (pulses != 2) begin
            n_err++;
            $display("FAIL frame_start_count got %0d want 2", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] fa, fb;
        bit got_b;
        int b_pos;
        fa = 16'($urandom);
        fb = 16'($urandom);
        idle_until(3);
        in_valid = 1'b1;
        in_data  = fa;
        tick();
        in_data = fb;
        got_b = 1'b0;
        b_pos = -1;
        for (int c = 0; c < 4 * FR; c++) begin
            tick();
            if (m_acc && !got_b) begin
                got_b    = 1'b1;
                b_pos    = int'((m_k - 1) % FR);
                in_valid = 1'b0;
            end
            n_chk++;
            if ({seg_n, an_n, frame_start, in_ready} !== {e_seg, e_an, e_fs, e_rdy}) begin
                n_err++;
                $display("FAIL b2b k=%0d got %h/%b/%b/%b want %h/%b/%b/%b", m_k, seg_n, an_n, frame_start, in_ready, e_seg, e_an, e_fs, e_rdy);
            end
        end
        in_valid = 1'b0;
        n_chk++;
        if (b_pos != 0) begin
            n_err++;
            $display("FAIL b2b_accept_pos got %0d want 0", b_pos);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4 * FR && (m_pvld || (m_k % FR) != FR - 1); i++) tick();
        in_valid = 1'b1;
        in_data  = 16'h250D;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL simul_ready c=%0d got %b want 1", c, in_ready);
            end
            tick();
        end
        n_chk++;
        if ({seg_n, an_n, in_ready} !== {8'h0D, 2'b10, 1'b1}) begin
            n_err++;
            $display("FAIL simul_slot0 got %h/%b/%b want 0D/10/1", seg_n, an_n, in_ready);
        end
        for (int c = 0; c < FR; c++) begin
            tick();
            n_chk++;
            if ({seg_n, an_n, frame_start, in_ready} !== {e_seg, e_an, e_fs, e_rdy}) begin
                n_err++;
                $display("FAIL simul k=%0d got %h/%b/%b/%b want %h/%b/%b/%b", m_k, seg_n, an_n, frame_start, in_ready, e_seg, e_an, e_fs, e_rdy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        idle_until(5);
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        tick();
        in_valid = 1'b0;
        idle_until(12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({seg_n, an_n, frame_start, in_ready} !== {8'hFF, 2'b11, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL midrst got %h/%b/%b/%b want FF/11/0/1", seg_n, an_n, frame_start, in_ready);
        end
        for (int c = 0; c < 2 * FR + 2; c++) begin
            tick();
            n_chk++;
            if ({seg_n, in_ready} !== {8'hFF, 1'b1} || {an_n, frame_start} !== {e_an, e_fs}) begin
                n_err++;
                $display("FAIL midrst_after c=%0d got %h/%b/%b/%b want FF/%b/%b/1", c, seg_n, an_n, frame_start, in_ready, e_an, e_fs);
            end
        end
    endtask

`ifdef SEG_DIM_EN
    task automatic test_dim();
        int lit_cnt;
        logic [1:0] xa;
        dim_level = 3'd1;
        idle_until(5);
        in_valid = 1'b1;
        in_data  = 16'h9F03;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2 * FR && !(e_fs && !m_pvld); i++) tick();
        lit_cnt = 0;
        for (int c = 0; c < FR; c++) begin
            if (c > 0) tick();
            xa = 2'b11;
            if (c % RD == 2 || c % RD == 3) xa = ((c / RD) % N == 0) ? 2'b10 : 2'b01;
            lit_cnt += int'(an_n !== 2'b11);
            n_chk++;
            if (an_n !== xa) begin
                n_err++;
                $display("FAIL dim c=%0d got an=%b want %b", c, an_n, xa);
            end
        end
        n_chk++;
        if (lit_cnt != 4) begin
            n_err++;
            $display("FAIL dim_count got %0d want 4", lit_cnt);
        end
        dim_level = 3'd7;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst      = ($urandom_range(59) == 0);
            in_valid = $urandom_range(3) == 0;
            in_data  = 16'($urandom);
`ifdef SEG_DIM_EN
            dim_level = 3'($urandom);
`endif
            tick();
            n_chk++;
            if ({seg_n, an_n, frame_start, in_ready} !== {e_seg, e_an, e_fs, e_rdy}) begin
                n_err++;
                $display("FAIL random k=%0d got %h/%b/%b/%b want %h/%b/%b/%b", m_k, seg_n, an_n, frame_start, in_ready, e_seg, e_an, e_fs, e_rdy);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_frame();
`ifdef SEG_DIM_EN
        test_dim();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
